// File: rtl/sndcmd_tx.sv
// rtl/sndcmd_tx.sv - sound command transmitter: FIFO, cen_3m-aligned latch strobe, timed IRQ pulse.
// Optional macro SNDCMD_TX_DIRECT_EN adds direct_mode (unqueued writes, software-driven irq_trigger).
module sndcmd_tx #(
  parameter int DEPTH_LOG2 = 2,
  parameter int IRQ_HI_CYC = 64,
  parameter int GAP_CYC    = 8192
) (
  input  logic       clk_49m,
  input  logic       reset,
  input  logic       cen_3m,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_data,
`ifdef SNDCMD_TX_DIRECT_EN
  input  logic       direct_mode,
`endif
  output logic       cs_sounddata,
  output logic [7:0] sound_data,
  output logic       irq_trigger,
  output logic       busy,
  output logic       full,
  output logic       overflow,
  input  logic       ovf_clr
);
  localparam int DEPTH   = 2 ** DEPTH_LOG2;
  localparam int MAX_CYC = (IRQ_HI_CYC > GAP_CYC) ? IRQ_HI_CYC : GAP_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]      HI_LOAD   = CNT_W'(IRQ_HI_CYC - 1);
  localparam logic [CNT_W-1:0]      GAP_LOAD  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LATCH, IRQ_HI, IRQ_LO} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  cs_nxt, irq_nxt;
  logic [7:0]            data_nxt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic                  push, pop, drop, direct_act;

  // Full is the registered flag, so a same-cycle pop never makes room for a write.
  always_comb begin
    direct_act = 1'b0;
`ifdef SNDCMD_TX_DIRECT_EN
    direct_act = direct_mode && (state == IDLE);
`endif
    push = cmd_wr && !full && !direct_act;
    drop = cmd_wr && full && !direct_act;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cs_nxt    = cs_sounddata;
    irq_nxt   = irq_trigger;
    data_nxt  = sound_data;
    pop       = 1'b0;
    case (state)
      IDLE: begin
`ifdef SNDCMD_TX_DIRECT_EN
        if (direct_act) begin
          if (cen_3m) cs_nxt = 1'b0;
          if (cmd_wr) begin
            cs_nxt   = 1'b1;
            data_nxt = cmd_data;
            if (cmd_data[7:1] == 7'h7F) irq_nxt = cmd_data[0];
          end
        end else
`endif
        if (count != '0) begin
          pop       = 1'b1;
          data_nxt  = mem[rd_ptr];
          cs_nxt    = 1'b1;
          irq_nxt   = 1'b0;
          state_nxt = LATCH;
        end else begin
          cs_nxt  = 1'b0;
          irq_nxt = 1'b0;
        end
      end
      LATCH: begin
        cs_nxt = 1'b1;
        if (cen_3m) begin
          cs_nxt    = 1'b0;
          irq_nxt   = 1'b1;
          cnt_nxt   = HI_LOAD;
          state_nxt = IRQ_HI;
        end
      end
      IRQ_HI: begin
        if (cnt == '0) begin
          irq_nxt   = 1'b0;
          cnt_nxt   = GAP_LOAD;
          state_nxt = IRQ_LO;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + COUNT_ONE;
    else if (pop && !push) count_nxt = count - COUNT_ONE;
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      cs_sounddata <= 1'b0;
      irq_trigger  <= 1'b0;
      sound_data   <= 8'h00;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cs_sounddata <= cs_nxt;
      irq_trigger  <= irq_nxt;
      sound_data   <= data_nxt;
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_CNT);
      busy         <= (count_nxt != '0) || (state_nxt != IDLE);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (ovf_clr)   overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_49m) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

endmodule
